// File: rtl/irq_encoder_8_3_pkg.sv
// Shared definitions for the interrupt encoder and the register-select decoder.
// State encoding and request/code widths live here so both sides agree.
package irq_encoder_8_3_pkg;

   localparam int IRQ_NUM    = 8;
   localparam int IRQ_CODE_W = 3;

   typedef enum logic {
      IRQ_IDLE  = 1'b0,
      IRQ_GRANT = 1'b1
   } irq_state_e;

endpackage

// File: rtl/prio_pick_8_3.sv
// Combinational 8-to-3 priority picker.
// PRIORITY_MSB=1 favours the highest set index, 0 the lowest.
module prio_pick_8_3
   import irq_encoder_8_3_pkg::*;
#(
   parameter bit PRIORITY_MSB = 1'b1
) (
   input  logic [IRQ_NUM-1:0]    in,
   output logic [IRQ_CODE_W-1:0] idx,
   output logic                  any
);

   always_comb begin
      idx = '0;
      any = |in;
      if (PRIORITY_MSB) begin
         for (int i = 0; i < IRQ_NUM; i++) begin
            if (in[i]) idx = i[IRQ_CODE_W-1:0];
         end
      end else begin
         for (int i = IRQ_NUM - 1; i >= 0; i--) begin
            if (in[i]) idx = i[IRQ_CODE_W-1:0];
         end
      end
   end

endmodule

// File: rtl/irq_encoder_8_3.sv
// Registered 8-to-3 priority encoder with request latching,
// valid/ack handshake, '148-style eo and a saturating drop counter.
module irq_encoder_8_3
   import irq_encoder_8_3_pkg::*;
#(
   parameter bit PRIORITY_MSB = 1'b1,
   parameter int CNT_W        = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [IRQ_NUM-1:0]    req_n,
   input  logic                  enable_n,
   input  logic                  ack,
   output logic [IRQ_CODE_W-1:0] code,
   output logic                  valid,
   output logic [IRQ_NUM-1:0]    pending,
   output logic                  eo,
   output logic [CNT_W-1:0]      drop_cnt
);

   irq_state_e state, state_nxt;

   logic [IRQ_NUM-1:0]    clr;
   logic [IRQ_NUM-1:0]    pend_nxt;
   logic [IRQ_CODE_W-1:0] code_nxt;
   logic [IRQ_CODE_W-1:0] pick_idx;
   logic                  pick_any;
   logic                  hit;
   logic                  valid_nxt;

   prio_pick_8_3 #(
      .PRIORITY_MSB(PRIORITY_MSB)
   ) u_pick (
      .in (pending),
      .idx(pick_idx),
      .any(pick_any)
   );

   assign valid = (state == IRQ_GRANT);

   always_comb begin
      clr = '0;
      if (valid && ack) clr[code] = 1'b1;
   end

   // A fresh request on the bit being acked keeps it pending.
   assign pend_nxt = (pending & ~clr) | ~req_n;
   assign hit      = |(~req_n & pending & ~clr);

   always_comb begin
      state_nxt = state;
      code_nxt  = code;
      unique case (state)
         IRQ_IDLE: begin
            if (!enable_n && pick_any) begin
               state_nxt = IRQ_GRANT;
               code_nxt  = pick_idx;
            end
         end
         IRQ_GRANT: begin
            if (ack) state_nxt = IRQ_IDLE;
         end
         default: state_nxt = IRQ_IDLE;
      endcase
   end

   assign valid_nxt = (state_nxt == IRQ_GRANT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IRQ_IDLE;
         code     <= '0;
         pending  <= '0;
         eo       <= 1'b0;
         drop_cnt <= '0;
      end else begin
         state   <= state_nxt;
         code    <= code_nxt;
         pending <= pend_nxt;
         eo      <= !enable_n && (pend_nxt == '0) && !valid_nxt;
         if (hit && (drop_cnt != {CNT_W{1'b1}})) begin
            drop_cnt <= drop_cnt + 1'b1;
         end
      end
   end

endmodule
